// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bubble and ebreak encodings, the default reset PC
// and the fetch FSM state type.
package cpu_pkg;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] EBREAK_INSN      = 32'h0010_0073;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch-stage performance counters: real fetches and inserted bubbles.
// Both counters wrap silently at 2^32.
module if_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        bubble_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  logic [31:0] fetch_cnt_r;
  logic [31:0] bubble_cnt_r;

  // Count fetch and bubble events, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_r  <= 32'h0000_0000;
      bubble_cnt_r <= 32'h0000_0000;
    end else begin
      if (fetch_inc) begin
        fetch_cnt_r <= fetch_cnt_r + 32'h0000_0001;
      end
      if (bubble_inc) begin
        bubble_cnt_r <= bubble_cnt_r + 32'h0000_0001;
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_r;
  assign bubble_cnt = bubble_cnt_r;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// RUN/HALT fetch FSM. Redirect beats stall; an ebreak latched into IF/ID
// halts fetching until the next redirect.
// Optional feature macro: IF_PERF_CNT_EN adds fetch_cnt / bubble_cnt.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_ir,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s;
  logic [31:0]  ir_r, ir_nxt_s;
  logic [31:0]  ipc_r, ipc_nxt_s;
  logic         valid_r, valid_nxt_s;

  // Next-state and next IF/ID contents; holding is the default.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ir_nxt_s    = ir_r;
    ipc_nxt_s   = ipc_r;
    valid_nxt_s = valid_r;
    case (state_r)
      ST_RUN: begin
        if (redirect) begin
          pc_nxt_s    = redirect_pc;
          ir_nxt_s    = NOP;
          ipc_nxt_s   = 32'h0000_0000;
          valid_nxt_s = 1'b0;
        end else if (stall) begin
          pc_nxt_s    = pc_r;
          ir_nxt_s    = ir_r;
          ipc_nxt_s   = ipc_r;
          valid_nxt_s = valid_r;
        end else begin
          pc_nxt_s    = pc_r + PC_STEP;
          ir_nxt_s    = imem_rdata;
          ipc_nxt_s   = pc_r;
          valid_nxt_s = 1'b1;
          // The ebreak itself still flows to decode with valid set.
          if (imem_rdata == EBREAK_INSN) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_HALT: begin
        ir_nxt_s    = NOP;
        ipc_nxt_s   = 32'h0000_0000;
        valid_nxt_s = 1'b0;
        if (redirect) begin
          pc_nxt_s    = redirect_pc;
          state_nxt_s = ST_RUN;
        end else begin
          pc_nxt_s    = pc_r;
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // PC, IF/ID register and FSM state, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      pc_r    <= RESET_PC;
      ir_r    <= NOP;
      ipc_r   <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      ir_r    <= ir_nxt_s;
      ipc_r   <= ipc_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Fetch address comes straight from the PC register only.
  assign imem_addr   = pc_r;
  assign if_id_ir    = ir_r;
  assign if_id_pc    = ipc_r;
  assign if_id_valid = valid_r;
  assign halted      = (state_r == ST_HALT);

`ifdef IF_PERF_CNT_EN
  logic fetch_s;
  logic bubble_s;

  assign fetch_s  = (state_r == ST_RUN) && !redirect && !stall;
  assign bubble_s = redirect || (state_r == ST_HALT);

  if_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst        (rst),
    .fetch_inc  (fetch_s),
    .bubble_inc (bubble_s),
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt)
  );
`endif

endmodule
